// File: rtl/nco_pkg.sv
// nco_pkg: shared constants for the cos/sin numerically controlled oscillator.
//   DEF_PHASE_W / DEF_LUT_AW / DEF_OUT_W : default widths of phase word, quarter-wave
//                                          index and signed output.
//   ONE_Q16  : +1.0 in the output scaling (2^16).
//   QUARTER  : 90 degrees in a default-width phase word (2^(PHASE_W-2)).
//   ROM_W    : magnitude width of a quarter-wave entry (0..65536 needs 17 bits).
//   quad_t   : quadrant code taken from the top two phase bits.
//   sin_q16  : elaboration-time generator for quarter-wave table entries.
package nco_pkg;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_LUT_AW  = 8;
  localparam int DEF_OUT_W   = 18;
  localparam int ONE_Q16     = 65536;
  localparam logic [DEF_PHASE_W-1:0] QUARTER = 32'h4000_0000;
  localparam int ROM_W       = 17;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,  // 0 .. 90 deg
    QUAD_1 = 2'd1,  // 90 .. 180 deg
    QUAD_2 = 2'd2,  // 180 .. 270 deg
    QUAD_3 = 2'd3   // 270 .. 360 deg
  } quad_t;

  // pi and 1.0 in Q30 fixed point, used only while building the table.
  localparam longint PI_Q30   = 64'sd3373259426;
  localparam longint ONE_Q30  = 64'sd1073741824;
  localparam longint HALF_Q30 = 64'sd536870912;

  // round(sin(k*pi/2^(lut_aw+1)) * 65536), evaluated with a Q30 Taylor
  // series (terms up to x^19). Only ever called with constant arguments,
  // so it folds to a literal per table entry. The end points are pinned so
  // that 0 and 90 degrees are exact regardless of series residue.
  function automatic logic [ROM_W-1:0] sin_q16(input int k, input int lut_aw);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint den;
    longint r;
    x    = (longint'(k) * PI_Q30) >>> (lut_aw + 1);
    x2   = (x * x) / ONE_Q30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      den  = longint'(2 * n) * longint'(2 * n + 1);
      term = -((term * x2) / ONE_Q30) / den;
      sum  = sum + term;
    end
    r = (sum * 64'sd65536 + HALF_Q30) >>> 30;
    if (k == 0) r = 64'sd0;
    if (k == (1 << lut_aw)) r = 64'sd65536;
    if (r > 64'sd65536) r = 64'sd65536;
    if (r < 64'sd0) r = 64'sd0;
    return r[ROM_W-1:0];
  endfunction

endpackage

// File: rtl/nco_qrom.sv
// nco_qrom: quarter-wave sine ROM with two independent registered read ports.
//   clk, rst           : clock and asynchronous active-high reset (clears read regs)
//   sin_idx, cos_idx   : table indices 0 .. 2^LUT_AW (one extra entry for 90 deg)
//   sin_val, cos_val   : table magnitudes, one cycle after the index, 0 .. 65536
module nco_qrom
  import nco_pkg::*;
#(
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW:0]   sin_idx,
  input  logic [LUT_AW:0]   cos_idx,
  output logic [ROM_W-1:0]  sin_val,
  output logic [ROM_W-1:0]  cos_val
);

  localparam int N = (1 << LUT_AW) + 1;

  logic [ROM_W-1:0] rom_w [0:N-1];

  // Each entry is an elaboration-time constant.
  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic [ROM_W-1:0] ENTRY = sin_q16(k, LUT_AW);
    assign rom_w[k] = ENTRY;
  end

  logic [ROM_W-1:0] sin_val_d, sin_val_q;
  logic [ROM_W-1:0] cos_val_d, cos_val_q;

  always_comb begin
    sin_val_d = rom_w[sin_idx];
    cos_val_d = rom_w[cos_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_val_q <= '0;
      cos_val_q <= '0;
    end else begin
      sin_val_q <= sin_val_d;
      cos_val_q <= cos_val_d;
    end
  end

  assign sin_val = sin_val_q;
  assign cos_val = cos_val_q;

endmodule

// File: rtl/nco_cos_sin.sv
// nco_cos_sin: phase-accumulator NCO producing signed cos/sin scaled by 2^16.
//   clk, rst   : single clock; asynchronous active-high reset clears every register
//   en         : advance the accumulator and mark this cycle's sample as valid
//   load       : synchronous accumulator clear, wins over en
//   FREQ       : phase increment per enabled cycle (unsigned, wraps)
//   PHASE_OFF  : phase offset added after the accumulator
//   COS, SIN   : cos/sin of the phase * 65536, two's complement, -65536 .. +65536
//   vld        : COS/SIN carry the sample of a cycle that had en=1
// Flow control: en is a valid strobe with no backpressure; the sample taken at
// edge t appears on COS/SIN/vld after edge t+2 (three register stages), so a
// consumer sees it at edge t+3. The pipeline always runs; vld alone qualifies.
// Stages: S1 phase add + quadrant fold, S2 ROM read, S3 sign apply.
module nco_cos_sin
  import nco_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW  = DEF_LUT_AW,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [PHASE_W-1:0]       FREQ,
  input  logic [PHASE_W-1:0]       PHASE_OFF,
  output logic signed [OUT_W-1:0]  COS,
  output logic signed [OUT_W-1:0]  SIN,
  output logic                     vld
);

  localparam int IDX_W  = LUT_AW + 1;
  localparam int LOW_HI = PHASE_W - 3 - LUT_AW;  // top of the truncated phase bits
  localparam logic [PHASE_W-1:0] QUARTER_W = {2'b01, {(PHASE_W-2){1'b0}}};
  localparam logic [IDX_W-1:0]   FULL_IDX  = {1'b1, {LUT_AW{1'b0}}};

  logic [PHASE_W-1:0] acc_d, acc_q;

  logic [PHASE_W-1:0] p_sin, p_cos;
  quad_t              sin_quad, cos_quad;
  logic [LUT_AW-1:0]  sin_i, cos_i;

  logic [IDX_W-1:0] sin_idx_d, sin_idx_q;
  logic [IDX_W-1:0] cos_idx_d, cos_idx_q;
  logic s1_sin_neg_d, s1_sin_neg_q, s1_cos_neg_d, s1_cos_neg_q;
  logic s2_sin_neg_d, s2_sin_neg_q, s2_cos_neg_d, s2_cos_neg_q;
  logic [2:0] vld_d, vld_q;

  logic [ROM_W-1:0] sin_rom, cos_rom;
  logic [OUT_W-1:0] sin_ext, cos_ext;
  logic signed [OUT_W-1:0] sin_d, sin_q, cos_d, cos_q;

  // Phase bits below the table index are dropped on purpose (no rounding).
  logic unused_low_bits;
  assign unused_low_bits = ^{p_sin[LOW_HI:0], p_cos[LOW_HI:0]};

  always_comb begin
    acc_d = acc_q;
    if (load)    acc_d = '0;
    else if (en) acc_d = acc_q + FREQ;

    // S1 samples the accumulator before this edge's update.
    p_sin    = acc_q + PHASE_OFF;
    p_cos    = p_sin + QUARTER_W;  // cos(x) = sin(x + 90 deg)
    sin_quad = quad_t'(p_sin[PHASE_W-1 -: 2]);
    cos_quad = quad_t'(p_cos[PHASE_W-1 -: 2]);
    sin_i    = p_sin[PHASE_W-3 -: LUT_AW];
    cos_i    = p_cos[PHASE_W-3 -: LUT_AW];

    // Odd quadrants run the quarter wave backwards; the upper half is negative.
    sin_idx_d = (sin_quad == QUAD_1 || sin_quad == QUAD_3) ?
                (FULL_IDX - {1'b0, sin_i}) : {1'b0, sin_i};
    cos_idx_d = (cos_quad == QUAD_1 || cos_quad == QUAD_3) ?
                (FULL_IDX - {1'b0, cos_i}) : {1'b0, cos_i};
    s1_sin_neg_d = (sin_quad == QUAD_2) || (sin_quad == QUAD_3);
    s1_cos_neg_d = (cos_quad == QUAD_2) || (cos_quad == QUAD_3);

    // Signs travel alongside the ROM read.
    s2_sin_neg_d = s1_sin_neg_q;
    s2_cos_neg_d = s1_cos_neg_q;

    sin_ext = {{(OUT_W-ROM_W){1'b0}}, sin_rom};
    cos_ext = {{(OUT_W-ROM_W){1'b0}}, cos_rom};
    sin_d   = s2_sin_neg_q ? -sin_ext : sin_ext;
    cos_d   = s2_cos_neg_q ? -cos_ext : cos_ext;

    vld_d = {vld_q[1:0], en};
  end

  nco_qrom #(
    .LUT_AW (LUT_AW)
  ) u_qrom (
    .clk     (clk),
    .rst     (rst),
    .sin_idx (sin_idx_q),
    .cos_idx (cos_idx_q),
    .sin_val (sin_rom),
    .cos_val (cos_rom)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      sin_idx_q    <= '0;
      cos_idx_q    <= '0;
      s1_sin_neg_q <= 1'b0;
      s1_cos_neg_q <= 1'b0;
      s2_sin_neg_q <= 1'b0;
      s2_cos_neg_q <= 1'b0;
      sin_q        <= '0;
      cos_q        <= '0;
      vld_q        <= '0;
    end else begin
      acc_q        <= acc_d;
      sin_idx_q    <= sin_idx_d;
      cos_idx_q    <= cos_idx_d;
      s1_sin_neg_q <= s1_sin_neg_d;
      s1_cos_neg_q <= s1_cos_neg_d;
      s2_sin_neg_q <= s2_sin_neg_d;
      s2_cos_neg_q <= s2_cos_neg_d;
      sin_q        <= sin_d;
      cos_q        <= cos_d;
      vld_q        <= vld_d;
    end
  end

  assign COS = cos_q;
  assign SIN = sin_q;
  assign vld = vld_q[2];

endmodule
